bcd_time_display_scan: RTL and testbench

- Downstream consumer of the 12-hour BCD time counter.
- Takes pm/hh/mm/ss and the same 1 Hz ena tick, snapshots the time coherently one cycle after each tick, then time-multiplexes six common-anode seven-segment digits (HH MM SS).
- Drives PM indicator, blinking colon separators, per-digit ghost blanking, and a sticky illegal-BCD flag.

---
 rtl/bcd_time_display_scan.sv | 159 +++++++++++++++
 tb/tb_bcd_time_display_scan.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_display_scan.sv
// bcd_time_display_scan
// Six-digit common-anode scanner for a 12-hour BCD clock (HH MM SS).
// The time is snapshotted one cycle after each seconds tick, then digits
// are multiplexed left to right with a short blanking window at the start
// of every slot to suppress ghosting. Also drives the PM dot, a blinking
// colon, and a sticky flag for illegal BCD nibbles.
// Optional build macro: LEADING_ZERO_BLANK_EN. When it is defined, the
// hours-tens digit is kept dark while the snapshot holds a 0 there.
module bcd_time_display_scan #(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned BLANK_CYC      = 2,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       pm,
    input  logic [7:0] hh,
    input  logic [7:0] mm,
    input  logic [7:0] ss,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic       bcd_err
);

    localparam logic [15:0] PRESC_LAST = 16'(SCAN_DIV - 1);
    localparam logic [15:0] BLANK_LIM  = 16'(BLANK_CYC);

    // scan timing
    logic [15:0] presc_q, presc_d;
    logic [2:0]  scan_q, scan_d;     // slot count since reset; digit = 5 - scan_q

    // coherent time snapshot
    logic        ena_d_q;
    logic        pm_q;
    logic [7:0]  hh_q, mm_q, ss_q;
    logic        colon_q;

    // registered outputs, kept in "lit" polarity
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;
    logic [5:0]  an_q, an_d;
    logic        err_q, err_d;

    // decode helpers
    logic [2:0]  digit;
    logic [3:0]  nib;
    logic [6:0]  glyph;
    logic        show;
    logic        dp_lit;

    // Prescaler wrap steps the scan slot; slot 0 after reset is the leftmost digit.
    always_comb begin
        presc_d = presc_q + 16'd1;
        scan_d  = scan_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            scan_d  = (scan_q == 3'd5) ? 3'd0 : scan_q + 3'd1;
        end
    end

    // Pick the nibble for the current digit, decode it and build next outputs.
    always_comb begin
        digit = 3'd5 - scan_q;
        case (digit)
            3'd5:    nib = hh_q[7:4];
            3'd4:    nib = hh_q[3:0];
            3'd3:    nib = mm_q[7:4];
            3'd2:    nib = mm_q[3:0];
            3'd1:    nib = ss_q[7:4];
            default: nib = ss_q[3:0];
        endcase

        case (nib)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h6F;
            default: glyph = 7'h79;  // "E" for any non-BCD nibble
        endcase

        show = !(presc_q < BLANK_LIM);
`ifdef LEADING_ZERO_BLANK_EN
        if (digit == 3'd5 && hh_q[7:4] == 4'd0) begin
            show = 1'b0;
        end
`else
`endif

        dp_lit = ((digit == 3'd4 || digit == 3'd2) && colon_q) ||
                 (digit == 3'd0 && pm_q);

        seg_d = show ? glyph : '0;
        dp_d  = show & dp_lit;
        an_d  = show ? (6'b000001 << digit) : '0;
        err_d = err_q | (show & (nib > 4'd9));
    end

    // Scan prescaler and slot counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            scan_q  <= '0;
        end else begin
            presc_q <= presc_d;
            scan_q  <= scan_d;
        end
    end

    // Snapshot the counter one cycle after its tick, when it has settled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ena_d_q <= 1'b0;
            pm_q    <= 1'b0;
            hh_q    <= 8'h12;
            mm_q    <= 8'h00;
            ss_q    <= 8'h00;
            colon_q <= 1'b1;
        end else begin
            ena_d_q <= ena;
            if (ena_d_q) begin
                pm_q    <= pm;
                hh_q    <= hh;
                mm_q    <= mm;
                ss_q    <= ss;
                colon_q <= ~colon_q;
            end
        end
    end

    // Output registers and sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_q <= '0;
            dp_q  <= 1'b0;
            an_q  <= '0;
            err_q <= 1'b0;
        end else begin
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
            err_q <= err_d;
        end
    end

    assign seg     = seg_q ^ {7{SEG_ACTIVE_LOW}};
    assign dp      = dp_q ^ SEG_ACTIVE_LOW;
    assign an      = an_q ^ {6{AN_ACTIVE_LOW}};
    assign bcd_err = err_q;

endmodule

// File: tb/tb_bcd_time_display_scan.sv
// Bench for bcd_time_display_scan: a time-indexed reference model checked
// every cycle, plus literal expectations for the key display scenarios.
module tb_bcd_time_display_scan;

    localparam int       DIV    = 8;
    localparam int       BLANK  = 2;
    localparam bit       SEG_LO = 1'b1;
    localparam bit       AN_LO  = 1'b1;

    logic       clk = 1'b0;
    logic       reset;
    logic       ena;
    logic       pm;
    logic [7:0] hh, mm, ss;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;
    logic       bcd_err;

    int checks = 0;
    int errors = 0;

    bcd_time_display_scan #(
        .SCAN_DIV(DIV),
        .BLANK_CYC(BLANK),
        .SEG_ACTIVE_LOW(SEG_LO),
        .AN_ACTIVE_LOW(AN_LO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ena(ena),
        .pm(pm),
        .hh(hh),
        .mm(mm),
        .ss(ss),
        .seg(seg),
        .dp(dp),
        .an(an),
        .bcd_err(bcd_err)
    );

    always #5 clk = ~clk;

    string seg_txt [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                            "acdefg", "abc", "abcdefg", "abcdfg", "adefg",
                            "adefg", "adefg", "adefg", "adefg", "adefg"};

    function automatic logic [6:0] glyph_of(input logic [3:0] d);
        string      s;
        logic [6:0] m;
        logic [2:0] b;
        m = '0;
        s = seg_txt[d];
        for (int i = 0; i < s.len(); i++) begin
            b = 3'(s[i] - 8'd97);
            m[b] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_n;
    bit         m_ena_d, m_pm, m_colon, m_err;
    logic [7:0] m_hh, m_mm, m_ss;
    logic [6:0] e_seg;
    logic       e_dp, e_err;
    logic [5:0] e_an;

    always @(negedge clk) begin
        int         pos, d;
        logic [3:0] v [6];
        bit         lit;
        logic [5:0] oh;
        if (!reset) begin
            chk("rst_an", 32'(an), 32'(AN_LO ? 6'h3F : 6'h00));
            chk("rst_seg", 32'(seg), 32'(SEG_LO ? 7'h7F : 7'h00));
            chk("rst_dp", 32'(dp), 32'(SEG_LO));
            chk("rst_err", 32'(bcd_err), 32'(0));
            m_n = 0; m_ena_d = 0; m_pm = 0; m_colon = 1; m_err = 0;
            m_hh = 8'h12; m_mm = 8'h00; m_ss = 8'h00;
            e_an = AN_LO ? 6'h3F : 6'h00;
            e_seg = SEG_LO ? 7'h7F : 7'h00;
            e_dp = SEG_LO;
            e_err = 1'b0;
        end else begin
            chk("scan_an", 32'(an), 32'(e_an));
            chk("scan_seg", 32'(seg), 32'(e_seg));
            chk("scan_dp", 32'(dp), 32'(e_dp));
            chk("scan_err", 32'(bcd_err), 32'(e_err));
            // prediction for the next edge from elapsed cycles since release
            pos = m_n % DIV;
            d = 5 - ((m_n / DIV) % 6);
            v[5] = m_hh[7:4]; v[4] = m_hh[3:0];
            v[3] = m_mm[7:4]; v[2] = m_mm[3:0];
            v[1] = m_ss[7:4]; v[0] = m_ss[3:0];
            lit = (pos >= BLANK);
`ifdef LEADING_ZERO_BLANK_EN
            if (d == 5 && v[5] == 4'd0) lit = 0;
`endif
            if (lit) begin
                oh = 6'(1 << d);
                e_an = AN_LO ? ~oh : oh;
                e_seg = SEG_LO ? ~glyph_of(v[d]) : glyph_of(v[d]);
                e_dp = (((d == 4 || d == 2) && m_colon) || (d == 0 && m_pm)) ^ SEG_LO;
                if (v[d] > 4'd9) m_err = 1;
            end else begin
                e_an = AN_LO ? 6'h3F : 6'h00;
                e_seg = SEG_LO ? 7'h7F : 7'h00;
                e_dp = SEG_LO;
            end
            e_err = m_err;
            if (m_ena_d) begin
                m_pm = pm; m_hh = hh; m_mm = mm; m_ss = ss;
                m_colon = !m_colon;
            end
            m_ena_d = ena;
            m_n++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_ena();
        ena = 1'b1;
        tick();
        ena = 1'b0;
    endtask

    task automatic wait_an(input logic [5:0] tgt, input string name);
        bit hit;
        hit = 0;
        for (int k = 0; k < 120; k++) begin
            tick();
            if (an == tgt) begin
                hit = 1;
                break;
            end
        end
        chk(name, 32'(hit), 32'(1));
    endtask

    task automatic new_time(input bit allow_bad);
        pm = 1'($urandom_range(0, 1));
        hh = bcd(int'($urandom_range(1, 12)));
        mm = bcd(int'($urandom_range(0, 59)));
        ss = bcd(int'($urandom_range(0, 59)));
        if (allow_bad && $urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 2))
                0:       hh[3:0] = 4'($urandom_range(10, 15));
                1:       mm[7:4] = 4'($urandom_range(10, 15));
                default: ss[3:0] = 4'($urandom_range(10, 15));
            endcase
        end
    endtask

    task automatic random_run(input int n, input bit allow_bad);
        int hold;
        hold = 0;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 15) == 0) new_time(allow_bad);
            if (hold == 0 && $urandom_range(0, 24) == 0) hold = int'($urandom_range(1, 3));
            ena = (hold > 0);
            if (hold > 0) hold--;
            tick();
        end
        ena = 1'b0;
    endtask

    task automatic do_reset();
        #1;
        reset = 1'b0;
        repeat (2) tick();
        #2;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; ena = 1'b0; pm = 1'b0;
        hh = 8'h00; mm = 8'h00; ss = 8'h00;
        repeat (3) tick();
        #2;
        reset = 1'b1;

        // power-up scan of 12:00:00 am
        for (int c = 1; c <= 51; c++) begin
            tick();
            if (c == 2)  chk("boot_blank", 32'(an), 32'(6'h3F));
            if (c == 3)  chk("boot_an5", 32'(an), 32'(6'b011111));
            if (c == 3)  chk("boot_seg1", 32'(seg), 32'(7'h79));
            if (c == 8)  chk("boot_an5_end", 32'(an), 32'(6'b011111));
            if (c == 9)  chk("boot_gap", 32'(an), 32'(6'h3F));
            if (c == 11) chk("boot_an4", 32'(an), 32'(6'b101111));
            if (c == 11) chk("boot_seg2", 32'(seg), 32'(7'h24));
            if (c == 11) chk("boot_colon", 32'(dp), 32'(0));
            if (c == 51) chk("boot_wrap", 32'(an), 32'(6'b011111));
        end

        // 11:59:58 pm snapshot
        hh = 8'h11; mm = 8'h59; ss = 8'h58; pm = 1'b1;
        pulse_ena();
        repeat (2) tick();
        wait_an(6'b111110, "pm_slot0");
        chk("pm_seg8", 32'(seg), 32'(7'h00));
        chk("pm_dp", 32'(dp), 32'(0));
        wait_an(6'b101111, "pm_slot4");
        chk("pm_colon_off", 32'(dp), 32'(1));

        // colon alternation across snapshots
        pulse_ena();
        repeat (2) tick();
        wait_an(6'b101111, "col_slot4_a");
        chk("col_on", 32'(dp), 32'(0));
        repeat (100) tick();
        pulse_ena();
        repeat (2) tick();
        wait_an(6'b111011, "col_slot2_b");
        chk("col_off", 32'(dp), 32'(1));

        random_run(2000, 1'b0);

        // illegal nibble and sticky error
        mm = 8'h5A;
        pulse_ena();
        repeat (2) tick();
        wait_an(6'b111011, "err_slot2");
        chk("err_segE", 32'(seg), 32'(7'h06));
        chk("err_set", 32'(bcd_err), 32'(1));
        mm = 8'h00;
        pulse_ena();
        repeat (60) tick();
        chk("err_sticky", 32'(bcd_err), 32'(1));

        // asynchronous reset mid-slot on index 3
        wait_an(6'b110111, "rst_slot3");
        #1;
        reset = 1'b0;
        #1;
        chk("arst_an", 32'(an), 32'(6'h3F));
        chk("arst_seg", 32'(seg), 32'(7'h7F));
        chk("arst_err", 32'(bcd_err), 32'(0));
        tick();
        tick();
        #2;
        reset = 1'b1;
        repeat (3) tick();
        chk("arst_restart_an", 32'(an), 32'(6'b011111));
        chk("arst_restart_seg", 32'(seg), 32'(7'h79));

        // leading zero on hours
        hh = 8'h09; mm = 8'h30; ss = 8'h15; pm = 1'b0;
        pulse_ena();
        repeat (2) tick();
        wait_an(6'b111110, "lz_slot0");
        for (int k = 0; k < 20 && an == 6'b111110; k++) tick();
        repeat (2) tick();
`ifdef LEADING_ZERO_BLANK_EN
        chk("lz_dark", 32'(an), 32'(6'h3F));
`else
        chk("lz_an5", 32'(an), 32'(6'b011111));
        chk("lz_seg0", 32'(seg), 32'(7'h40));
`endif

        random_run(3000, 1'b1);
        do_reset();
        random_run(500, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
